operand_loader: RTL and testbench
=================================

OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand width in bits.
REQ-002 The module SHALL have parameter SYNC_STAGES, default 2, giving the number of strobe synchronizer flops (minimum 2).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 data_in  input  WIDTH  write data from the external pins.
REQ-006 strobe  input  1  asynchronous write strobe; each rising edge is one write event.
REQ-007 abort  input  1  synchronous; discards the partial or presented operand set.
REQ-008 op_ready  input  1  downstream ALU consumes the presented operands.
REQ-009 A  output  WIDTH  operand A to the ALU datapath.
REQ-010 B  output  WIDTH  operand B, raw, to the B-inversion mux.
REQ-011 ALUControl  output  2  ALU operation select; bit 0 drives the B-inversion select.
REQ-012 op_valid  output  1  A, B and ALUControl form a complete, stable set.
REQ-013 load_idx  output  2  current FSM state encoding.

Function
REQ-014 strobe SHALL pass through a SYNC_STAGES-flop synchronizer; a write event SHALL be a 0->1 transition of the last stage versus its registered previous value.
REQ-015 With SYNC_STAGES=2, data_in SHALL be captured on the 3rd rising clk edge after strobe is first sampled high; data_in must be stable over that window.
REQ-016 One strobe pulse, of any length of at least 1 clk, SHALL produce exactly one write event; strobe low time must also be at least 1 clk.
REQ-017 FSM states: LOAD_A=0, LOAD_B=1, LOAD_CTRL=2, PRESENT=3; load_idx SHALL equal the state.
REQ-018 In LOAD_A, a write event SHALL load A from data_in and go to LOAD_B.
REQ-019 In LOAD_B, a write event SHALL load B from data_in and go to LOAD_CTRL.
REQ-020 In LOAD_CTRL, a write event SHALL load ALUControl from data_in[1:0], ignore data_in[WIDTH-1:2], and go to PRESENT.
REQ-021 op_valid SHALL be 1 exactly when the state is PRESENT, registered, with no combinational path from inputs.
REQ-022 In PRESENT, write events SHALL be discarded and not buffered, and A, B and ALUControl SHALL hold.
REQ-023 In PRESENT with op_ready=1, the next state SHALL be LOAD_A and op_valid SHALL fall on that edge.
REQ-024 op_ready outside PRESENT SHALL be ignored.
REQ-025 A, B and ALUControl SHALL retain their last values when leaving PRESENT or on abort; they are never cleared except by rst.
REQ-026 abort=1 SHALL force LOAD_A at the next edge from any state and SHALL leave A, B and ALUControl unchanged.
REQ-027 abort together with a write event SHALL give abort priority, and the write SHALL be discarded.
REQ-028 abort together with op_ready in PRESENT SHALL go to LOAD_A, the same result as either alone.
REQ-029 A write event coinciding with op_ready in PRESENT SHALL be discarded and SHALL NOT count as the next A write.

Reset
REQ-030 On rst: state=LOAD_A, op_valid=0, A=0, B=0, ALUControl=0, load_idx=0.
REQ-031 On rst, all synchronizer stages and the edge-detect previous-value flop SHALL be set to 1, so a strobe held high through reset produces no write event.
REQ-032 rst asserted mid-sequence SHALL discard all progress; rst SHALL override abort, write events and op_ready.

Structure
REQ-033 A shared package alu_pkg SHALL hold the FSM state typedef, its encodings and the constant ALUCTRL_W=2.
REQ-034 The synchronizer and rising-edge detector SHALL be one sub-module, sync_edge_detect (parameter SYNC_STAGES, reset value 1), giving a single-cycle pulse.
REQ-035 The outputs SHALL drive the ALU datapath directly, with no added combinational logic.

Verification
REQ-036 Sequence: strobe writes 0x3C, 0x05, 0x01 -> A=0x3C, B=0x05, ALUControl=1, op_valid=1, load_idx=3; op_ready pulse -> op_valid=0 next edge, A/B/ALUControl held.
REQ-037 Latency: strobe rises, then count edges -> A updates on exactly the 3rd edge; a strobe held high 10 clk -> exactly one write.
REQ-038 In PRESENT: strobe a 4th write of 0xFF -> discarded; after op_ready, next write 0x11 -> A=0x11 (not 0xFF).
REQ-039 Abort after the A write, abort coinciding with the B write, and abort in PRESENT -> load_idx=0, op_valid=0, registers unchanged.
REQ-040 rst asserted in LOAD_CTRL with strobe high -> all outputs 0; strobe held high through rst release -> no write; strobe then falls and rises -> A captured.
REQ-041 ALUControl write of 0xFE -> ALUControl=2 (upper bits ignored).

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared operand-loader state encodings and ALU control width
package alu_pkg;
   localparam int ALUCTRL_W = 2;
   typedef logic [1:0] state_t;
   localparam state_t LOAD_A    = 2'd0;
   localparam state_t LOAD_B    = 2'd1;
   localparam state_t LOAD_CTRL = 2'd2;
   localparam state_t PRESENT   = 2'd3;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-flop synchronizer with single-cycle rising-edge pulse
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic pulse
);
   logic [SYNC_STAGES-1:0] sync;
   logic prev;
   // reset to 1 so a level held high through reset never looks like an edge
   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= '1;
         prev <= 1'b1;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], din};
         prev <= sync[SYNC_STAGES-1];
      end
   end
   assign pulse = sync[SYNC_STAGES-1] & ~prev;
endmodule

// File: rtl/operand_loader.sv
// operand_loader: strobe-driven sequential loader of A, B and ALUControl for the ALU
module operand_loader
   import alu_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     data_in,
   input  logic                 strobe,
   input  logic                 abort,
   input  logic                 op_ready,
   output logic [WIDTH-1:0]     A,
   output logic [WIDTH-1:0]     B,
   output logic [ALUCTRL_W-1:0] ALUControl,
   output logic                 op_valid,
   output logic [1:0]           load_idx
);
   state_t state, state_nxt;
   logic wr, ld;
   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk),
      .rst(rst),
      .din(strobe),
      .pulse(wr)
   );
   assign ld = wr & ~abort;
   // load states are consecutive encodings, so a write simply advances by one
   always_comb begin
      state_nxt = abort ? LOAD_A
                : state == PRESENT ? (op_ready ? LOAD_A : PRESENT)
                : wr ? state_t'(state + 2'd1)
                : state;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= LOAD_A;
         op_valid   <= 1'b0;
         A          <= '0;
         B          <= '0;
         ALUControl <= '0;
      end else begin
         state    <= state_nxt;
         op_valid <= state_nxt == PRESENT;
         if (ld && state == LOAD_A) A <= data_in;
         if (ld && state == LOAD_B) B <= data_in;
         if (ld && state == LOAD_CTRL) ALUControl <= data_in[ALUCTRL_W-1:0];
      end
   end
   assign load_idx = state;
endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: directed self-checking bench for operand_loader
module tb_operand_loader;
   logic       clk = 1'b0;
   logic       rst, strobe, abort, op_ready;
   logic [7:0] data_in, A, B;
   logic [1:0] ALUControl, load_idx;
   logic       op_valid;
   int         checks = 0, failures = 0;

   operand_loader #(.WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .strobe(strobe), .abort(abort),
      .op_ready(op_ready), .A(A), .B(B), .ALUControl(ALUControl),
      .op_valid(op_valid), .load_idx(load_idx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic wr(input logic [7:0] d);
      data_in = d;
      strobe = 1'b1;
      @(negedge clk);
      strobe = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic regs(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] c, input logic v, input logic [1:0] idx);
      check({tag, ".A"}, A, a);
      check({tag, ".B"}, B, b);
      check({tag, ".ctrl"}, ALUControl, c);
      check({tag, ".valid"}, op_valid, v);
      check({tag, ".idx"}, load_idx, idx);
   endtask

   initial begin
      rst = 1'b1; strobe = 1'b0; abort = 1'b0; op_ready = 1'b0; data_in = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      regs("reset", 8'h00, 8'h00, 2'd0, 1'b0, 2'd0);
      wr(8'h3C);
      wr(8'h05);
      regs("after_b", 8'h3C, 8'h05, 2'd0, 1'b0, 2'd2);
      wr(8'h01);
      regs("present", 8'h3C, 8'h05, 2'd1, 1'b1, 2'd3);
      wr(8'hFF);
      regs("discard4", 8'h3C, 8'h05, 2'd1, 1'b1, 2'd3);
      op_ready = 1'b1;
      @(negedge clk);
      op_ready = 1'b0;
      regs("consumed", 8'h3C, 8'h05, 2'd1, 1'b0, 2'd0);
      wr(8'h11);
      check("a_after_discard", A, 8'h11);
      check("idx_after_a", load_idx, 2'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      regs("abort_after_a", 8'h11, 8'h05, 2'd1, 1'b0, 2'd0);
      // capture latency and a long strobe
      data_in = 8'h5A;
      strobe = 1'b1;
      @(negedge clk);
      check("lat_edge1", A, 8'h11);
      @(negedge clk);
      check("lat_edge2", A, 8'h11);
      @(negedge clk);
      check("lat_edge3", A, 8'h5A);
      repeat (7) @(negedge clk);
      strobe = 1'b0;
      repeat (4) @(negedge clk);
      check("long_strobe_one_write", load_idx, 2'd1);
      // abort on the same edge as the B write event
      data_in = 8'h77;
      strobe = 1'b1;
      repeat (2) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      strobe = 1'b0;
      repeat (4) @(negedge clk);
      regs("abort_with_b", 8'h5A, 8'h05, 2'd1, 1'b0, 2'd0);
      wr(8'h22);
      wr(8'h33);
      wr(8'hFE);
      regs("ctrl_fe", 8'h22, 8'h33, 2'd2, 1'b1, 2'd3);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      regs("abort_present", 8'h22, 8'h33, 2'd2, 1'b0, 2'd0);
      op_ready = 1'b1;
      repeat (2) @(negedge clk);
      op_ready = 1'b0;
      check("op_ready_ignored", load_idx, 2'd0);
      wr(8'h44);
      wr(8'h55);
      wr(8'h03);
      abort = 1'b1;
      op_ready = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      op_ready = 1'b0;
      regs("abort_and_ready", 8'h44, 8'h55, 2'd3, 1'b0, 2'd0);
      // write event on the same edge op_ready is consumed
      wr(8'h01);
      wr(8'h02);
      wr(8'h03);
      data_in = 8'hEE;
      strobe = 1'b1;
      repeat (2) @(negedge clk);
      op_ready = 1'b1;
      @(negedge clk);
      op_ready = 1'b0;
      strobe = 1'b0;
      repeat (4) @(negedge clk);
      regs("write_with_ready", 8'h01, 8'h02, 2'd3, 1'b0, 2'd0);
      // reset mid-sequence with strobe held high through release
      wr(8'h10);
      wr(8'h20);
      check("pre_rst_idx", load_idx, 2'd2);
      data_in = 8'h99;
      strobe = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      regs("rst_mid", 8'h00, 8'h00, 2'd0, 1'b0, 2'd0);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      regs("strobe_thru_rst", 8'h00, 8'h00, 2'd0, 1'b0, 2'd0);
      strobe = 1'b0;
      repeat (3) @(negedge clk);
      wr(8'hAB);
      check("post_rst_a", A, 8'hAB);
      check("post_rst_idx", load_idx, 2'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
